// File: rtl/t03_clock_alarm_reader.sv
// t03_clock_alarm_reader
//   Consumes the free-running 32-bit tick counter from the hardware clock
//   block. Exposes it to the CPU over a req/ack register bus and raises a
//   level interrupt when the counter reaches a programmable compare value.
//   The compare value can optionally be reloaded periodically.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   tick_count  tick counter input (increments by 1, holds between ticks)
//   bus_req     access request, held until bus_ack is seen
//   bus_we      1 = write, 0 = read
//   bus_addr    word index: 0 COUNT, 1 COMPARE, 2 PERIOD, 3 CTRL, 4 STATUS
//   bus_wdata   write data
//   bus_ack     one-cycle access acknowledge
//   bus_rdata   read data, valid in the bus_ack cycle only, else 0
//   irq         registered STATUS.pending & CTRL.irq_en
//
// Configuration
//   T03_ALARM_OVERRUN_EN  adds STATUS bit1 overrun (match while pending set)

module t03_clock_alarm_reader #(
   parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF,
   parameter logic [31:0] PERIOD_RST  = 32'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tick_count,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [2:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic [31:0] bus_rdata,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, RESP, RELEASE} state_t;

   state_t      state, state_nxt;
   logic        we_q;
   logic [2:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] count_q;

   logic [31:0] compare;
   logic [31:0] period;
   logic [2:0]  ctrl;       // bit0 enable, bit1 periodic, bit2 irq_en
   logic        pending;
   logic        overrun;
   logic [31:0] prev_tick;

   logic        tick_event;
   logic        match;
   logic        wr;
   logic [31:0] rd_mux;

   assign tick_event = (tick_count != prev_tick);
   assign match      = ctrl[0] & tick_event & (tick_count == compare);
   assign wr         = (state == RESP) & we_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Access attributes and COUNT snapshot are taken in the request cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
      end else if (state == IDLE && bus_req) begin
         we_q    <= bus_we;
         addr_q  <= bus_addr;
         wdata_q <= bus_wdata;
         count_q <= tick_count;
      end
   end

   always_comb begin
      case (addr_q)
         3'd0:    rd_mux = count_q;
         3'd1:    rd_mux = compare;
         3'd2:    rd_mux = period;
         3'd3:    rd_mux = {29'd0, ctrl};
         3'd4:    rd_mux = {30'd0, overrun, pending};
         default: rd_mux = '0;
      endcase
   end

   // Ack is masked by rst so a reset landing in the response cycle
   // aborts the access without a visible acknowledge.
   always_comb begin
      state_nxt = state;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      case (state)
         IDLE:    if (bus_req) state_nxt = RESP;
         RESP: begin
            bus_ack   = ~rst;
            bus_rdata = rst ? '0 : rd_mux;
            state_nxt = RELEASE;
         end
         RELEASE: if (!bus_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // CPU writes are applied after the hardware updates so they take priority,
   // except for pending/overrun where a match (set) beats the W1C clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         compare   <= COMPARE_RST;
         period    <= PERIOD_RST;
         ctrl      <= '0;
         pending   <= 1'b0;
         prev_tick <= '0;
      end else begin
         prev_tick <= tick_count;
         if (match) begin
            if (ctrl[1]) compare <= compare + period;
            else         ctrl[0] <= 1'b0;
         end
         if (wr) begin
            case (addr_q)
               3'd1: compare <= wdata_q;
               3'd2: period  <= wdata_q;
               3'd3: ctrl    <= wdata_q[2:0];
               3'd4: if (wdata_q[0]) pending <= 1'b0;
               default: ;
            endcase
         end
         if (match) pending <= 1'b1;
      end
   end

`ifdef T03_ALARM_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (match && pending) begin
         overrun <= 1'b1;
      end else if (wr && addr_q == 3'd4 && wdata_q[1]) begin
         overrun <= 1'b0;
      end
   end
`else
   assign overrun = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= pending & ctrl[2];
   end

endmodule

// File: tb/tb_t03_clock_alarm_reader.sv
module tb_t03_clock_alarm_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tick_count;
   logic        bus_req;
   logic        bus_we;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        irq;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   t03_clock_alarm_reader #(
      .COMPARE_RST(32'hFFFF_FFFF),
      .PERIOD_RST (32'd1000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_count(tick_count),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .irq       (irq)
   );

   // Reference model: register contents as the CPU sees them.
   logic [31:0] m_cmp, m_per, m_prev;
   logic [2:0]  m_ctrl;
   logic        m_pend, m_ovr, m_irq;
   // Write committed by the DUT at the coming edge.
   logic        commit_now;
   logic        c_we;
   logic [2:0]  c_addr;
   logic [31:0] c_wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mread(input logic [2:0] a, input logic [31:0] cnt);
      case (a)
         3'd0:    return cnt;
         3'd1:    return m_cmp;
         3'd2:    return m_per;
         3'd3:    return {29'd0, m_ctrl};
         3'd4:    return {30'd0, m_ovr, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   // Advance one clock: predict the edge from the rules, then check irq.
   task automatic step();
      logic        ev, mt, npend, novr, nirq;
      logic [31:0] ncmp, nper;
      logic [2:0]  nctrl;
      ev    = (tick_count != m_prev);
      mt    = m_ctrl[0] && ev && (tick_count == m_cmp);
      ncmp  = m_cmp;  nper = m_per;  nctrl = m_ctrl;
      npend = m_pend; novr = m_ovr;
      nirq  = m_pend & m_ctrl[2];
      if (mt) begin
         if (m_ctrl[1]) ncmp = m_cmp + m_per;
         else           nctrl[0] = 1'b0;
      end
      if (commit_now && c_we) begin
         case (c_addr)
            3'd1: ncmp  = c_wd;
            3'd2: nper  = c_wd;
            3'd3: nctrl = c_wd[2:0];
            3'd4: begin
               if (c_wd[0]) npend = 1'b0;
`ifdef T03_ALARM_OVERRUN_EN
               if (c_wd[1]) novr = 1'b0;
`endif
            end
            default: ;
         endcase
      end
      if (mt) begin
`ifdef T03_ALARM_OVERRUN_EN
         if (m_pend) novr = 1'b1;
`endif
         npend = 1'b1;
      end
      if (rst) begin
         ncmp = 32'hFFFF_FFFF; nper = 32'd1000; nctrl = 3'd0;
         npend = 1'b0; novr = 1'b0; nirq = 1'b0;
      end
      @(posedge clk);
      m_cmp  = ncmp;  m_per = nper; m_ctrl = nctrl;
      m_pend = npend; m_ovr = novr; m_irq  = nirq;
      m_prev = rst ? 32'd0 : tick_count;
      commit_now = 1'b0;
      #1;
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic tick_to(input logic [31:0] v);
      tick_count = v;
      step();
   endtask

   // One bus access; req held for 'hold' cycles past the ack cycle.
   task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] wd,
                       input int hold, input bit bump, output logic [31:0] rd);
      logic [31:0] cnt;
      cnt       = tick_count;
      bus_req   = 1'b1;
      bus_we    = we;
      bus_addr  = a;
      bus_wdata = wd;
      step();
      chk("ack_latency", {31'd0, bus_ack}, 32'd1);
      rd = bus_rdata;
      if (!we) chk("rdata", bus_rdata, mread(a, cnt));
      commit_now = 1'b1; c_we = we; c_addr = a; c_wd = wd;
      if (bump) tick_count = tick_count + 32'd1;
      step();
      chk("ack_single", {31'd0, bus_ack}, 32'd0);
      for (int i = 1; i < hold; i++) begin
         step();
         chk("ack_held", {31'd0, bus_ack}, 32'd0);
      end
      bus_req = 1'b0;
      bus_we  = 1'b0;
      step();
      chk("ack_idle", {31'd0, bus_ack}, 32'd0);
      chk("rdata_idle", bus_rdata, 32'd0);
   endtask

   initial begin
      logic [31:0] rd, wd, t;
      logic [2:0]  a;
      logic        we;
      rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      tick_count = '0; commit_now = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
      m_cmp = 32'hFFFF_FFFF; m_per = 32'd1000; m_ctrl = '0;
      m_pend = 1'b0; m_ovr = 1'b0; m_irq = 1'b0; m_prev = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_ack", {31'd0, bus_ack}, 32'd0);
      chk("rst_rdata", bus_rdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      xfer(1'b0, 3'd3, '0, 1, 1'b0, rd); chk("rst_ctrl", rd, 32'd0);
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("rst_compare", rd, 32'hFFFF_FFFF);
      xfer(1'b0, 3'd2, '0, 1, 1'b0, rd); chk("rst_period", rd, 32'd1000);

      // Long request: one ack, COUNT snapshot from the request cycle
      tick_to(32'h77);
      xfer(1'b0, 3'd0, '0, 5, 1'b1, rd); chk("count_snapshot", rd, 32'h77);

      // One-shot match at tick 5
      tick_to(32'd0);
      xfer(1'b1, 3'd1, 32'd5, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd5, 1, 1'b0, rd);
      for (int v = 1; v <= 6; v++) tick_to(v);
      chk("oneshot_irq", {31'd0, irq}, 32'd1);
      xfer(1'b0, 3'd4, '0, 1, 1'b0, rd); chk("oneshot_pending", rd & 32'd1, 32'd1);
      xfer(1'b0, 3'd3, '0, 1, 1'b0, rd); chk("oneshot_disable", rd, 32'd4);
      xfer(1'b1, 3'd4, 32'd3, 1, 1'b0, rd);

      // Periodic matches at 10, 20, 30
      xfer(1'b1, 3'd1, 32'd10, 1, 1'b0, rd);
      xfer(1'b1, 3'd2, 32'd10, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd7, 1, 1'b0, rd);
      for (int v = 7; v <= 35; v++) tick_to(v);
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("periodic_compare", rd, 32'd40);
      xfer(1'b1, 3'd3, 32'd0, 1, 1'b0, rd);
      xfer(1'b1, 3'd4, 32'd3, 1, 1'b0, rd);

      // Compare reload wraps modulo 2^32, match after the tick counter wraps
      tick_to(32'hFFFF_FFE0);
      xfer(1'b1, 3'd2, 32'h20, 1, 1'b0, rd);
      xfer(1'b1, 3'd1, 32'hFFFF_FFF0, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd3, 1, 1'b0, rd);
      for (int k = 1; k <= 16; k++) tick_to(32'hFFFF_FFE0 + k);
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("wrap_compare", rd, 32'h10);
      xfer(1'b1, 3'd4, 32'd3, 1, 1'b0, rd);
      for (int k = 17; k <= 48; k++) tick_to(32'hFFFF_FFE0 + k);
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("wrap_compare2", rd, 32'h30);
      xfer(1'b0, 3'd4, '0, 1, 1'b0, rd); chk("wrap_pending", rd & 32'd1, 32'd1);
      xfer(1'b1, 3'd3, 32'd0, 1, 1'b0, rd);
      xfer(1'b1, 3'd4, 32'd3, 1, 1'b0, rd);

      // W1C clear in the same cycle as a match: set wins
      xfer(1'b1, 3'd1, tick_count + 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd4, 32'd1, 1, 1'b1, rd);
      xfer(1'b0, 3'd4, '0, 1, 1'b0, rd); chk("w1c_vs_match", rd & 32'd1, 32'd1);

      // Further matches while pending
      xfer(1'b1, 3'd2, 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd1, tick_count + 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd3, 1, 1'b0, rd);
      t = tick_count;
      tick_to(t + 32'd1);
      tick_to(t + 32'd2);
      xfer(1'b0, 3'd4, '0, 1, 1'b0, rd);
`ifdef T03_ALARM_OVERRUN_EN
      chk("overrun", rd, 32'd3);
`else
      chk("no_overrun", rd, 32'd1);
`endif

      // CPU write to COMPARE beats periodic reload in the same cycle
      xfer(1'b1, 3'd1, tick_count + 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd1, 32'h500, 1, 1'b1, rd);
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("cmp_write_wins", rd, 32'h500);

      // CPU write to CTRL beats one-shot auto-disable in the same cycle
      xfer(1'b1, 3'd3, 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd1, tick_count + 32'd1, 1, 1'b0, rd);
      xfer(1'b1, 3'd3, 32'd5, 1, 1'b1, rd);
      xfer(1'b0, 3'd3, '0, 1, 1'b0, rd); chk("ctrl_write_wins", rd, 32'd5);

      // Reset in the response cycle aborts the access
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd1; bus_wdata = 32'h1234;
      step();
      rst = 1'b1;
      #1;
      chk("rst_abort_ack", {31'd0, bus_ack}, 32'd0);
      step();
      rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0;
      step();
      xfer(1'b0, 3'd1, '0, 1, 1'b0, rd); chk("rst_abort_compare", rd, 32'hFFFF_FFFF);

      // Randomized accesses against the model
      for (int n = 0; n < 80; n++) begin
         a  = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         if (a == 3'd1) wd = tick_count + 32'($urandom_range(0, 4));
         if (a == 3'd2) wd = 32'($urandom_range(0, 3));
         xfer(we, a, wd, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), rd);
         repeat ($urandom_range(0, 3)) tick_to(tick_count + 32'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
